// File: rtl/vedic_mul_pipelined.sv
// Three-stage pipelined multiplier for the execute lane (RISC-V MUL/MULH/MULHSU/MULHU).
// Operands are sign-conditioned to magnitudes, split into halves, multiplied by four
// half-width vedic (vertically-and-crosswise) multipliers, then recombined and re-signed.
module vedic_mul_pipelined #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned IW = $clog2(H);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  // Urdhva-tiryagbhyam: each product column k sums the crosswise bit pairs a[i]&b[k-i].
  function automatic logic [WIDTH-1:0] vedic_hmul(input logic [H-1:0] a, input logic [H-1:0] b);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] col;
    acc = '0;
    for (int unsigned k = 0; k < 2*H-1; k++) begin
      col = '0;
      for (int unsigned i = 0; i < H; i++) begin
        if ((i <= k) && ((k - i) < H))
          col = col + {{(WIDTH-1){1'b0}}, a[IW'(i)] & b[IW'(k - i)]};
      end
      acc = acc + (col << k);
    end
    return acc;
  endfunction

  // Stage 1: conditioned operands
  logic              r_s1_valid;
  op_e               r_s1_op;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s1_neg;
  logic [WIDTH-1:0]  r_s1_mag_a;
  logic [WIDTH-1:0]  r_s1_mag_b;

  // Stage 2: partial products
  logic              r_s2_valid;
  op_e               r_s2_op;
  logic [TAG_W-1:0]  r_s2_tag;
  logic              r_s2_neg;
  logic [WIDTH-1:0]  r_s2_ll;
  logic [WIDTH-1:0]  r_s2_lh;
  logic [WIDTH-1:0]  r_s2_hl;
  logic [WIDTH-1:0]  r_s2_hh;

  // Stage 3: output register
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_result;
  logic [2*WIDTH-1:0]  r_out_product;
  logic [TAG_W-1:0]    r_out_tag;

  logic              w_en;
  op_e               w_op;
  logic              w_sign_a;
  logic              w_sign_b;
  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic [WIDTH-1:0]  w_ll;
  logic [WIDTH-1:0]  w_lh;
  logic [WIDTH-1:0]  w_hl;
  logic [WIDTH-1:0]  w_hh;
  logic [WIDTH:0]    w_mid;
  logic [2*WIDTH-1:0] w_p;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]  w_res;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en && !flush;
  assign w_op     = op_e'(in_op);

  always_comb begin
    w_sign_a = (w_op != OP_MULHU) && in_a[WIDTH-1];
    w_sign_b = ((w_op == OP_MUL) || (w_op == OP_MULH)) && in_b[WIDTH-1];
    // The most negative value negates to itself, which read unsigned is 2^(W-1).
    w_mag_a  = w_sign_a ? -in_a : in_a;
    w_mag_b  = w_sign_b ? -in_b : in_b;
  end

  always_comb begin
    w_ll = vedic_hmul(r_s1_mag_a[H-1:0],     r_s1_mag_b[H-1:0]);
    w_lh = vedic_hmul(r_s1_mag_a[H-1:0],     r_s1_mag_b[WIDTH-1:H]);
    w_hl = vedic_hmul(r_s1_mag_a[WIDTH-1:H], r_s1_mag_b[H-1:0]);
    w_hh = vedic_hmul(r_s1_mag_a[WIDTH-1:H], r_s1_mag_b[WIDTH-1:H]);
  end

  always_comb begin
    w_mid  = {1'b0, r_s2_lh} + {1'b0, r_s2_hl};
    w_p    = {{WIDTH{1'b0}}, r_s2_ll}
           + {{(H-1){1'b0}}, w_mid, {H{1'b0}}}
           + {r_s2_hh, {WIDTH{1'b0}}};
    w_prod = r_s2_neg ? -w_p : w_p;
    w_res  = (r_s2_op == OP_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_op       <= OP_MUL;
      r_s1_tag      <= '0;
      r_s1_neg      <= 1'b0;
      r_s1_mag_a    <= '0;
      r_s1_mag_b    <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_op       <= OP_MUL;
      r_s2_tag      <= '0;
      r_s2_neg      <= 1'b0;
      r_s2_ll       <= '0;
      r_s2_lh       <= '0;
      r_s2_hl       <= '0;
      r_s2_hh       <= '0;
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_product <= '0;
      r_out_tag     <= '0;
    end else if (flush) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_op    <= w_op;
      r_s1_tag   <= in_tag;
      r_s1_neg   <= w_sign_a ^ w_sign_b;
      r_s1_mag_a <= w_mag_a;
      r_s1_mag_b <= w_mag_b;

      r_s2_valid <= r_s1_valid;
      r_s2_op    <= r_s1_op;
      r_s2_tag   <= r_s1_tag;
      r_s2_neg   <= r_s1_neg;
      r_s2_ll    <= w_ll;
      r_s2_lh    <= w_lh;
      r_s2_hl    <= w_hl;
      r_s2_hh    <= w_hh;

      r_out_valid <= r_s2_valid;
      // Output data only moves on a real result so a bubble leaves the last result visible.
      if (r_s2_valid) begin
        r_out_result  <= w_res;
        r_out_product <= w_prod;
        r_out_tag     <= r_s2_tag;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_product = r_out_product;
  assign out_tag     = r_out_tag;

endmodule

// File: tb/tb_vedic_mul_pipelined.sv
// Self-checking bench for vedic_mul_pipelined: directed corner products, backpressure,
// flush, asynchronous reset and randomized streams at WIDTH 32 plus 8, 16 and 64 instances.
module tb_vedic_mul_pipelined;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]      in_op;
  logic [W-1:0]    in_a, in_b, out_result;
  logic [2*W-1:0]  out_product;
  logic [TW-1:0]   in_tag, out_tag;

  logic v8_iv, v8_ir, v8_ov, v8_or;    logic [1:0] v8_op;
  logic [7:0]  v8_a, v8_b, v8_res;     logic [15:0]  v8_prod;  logic [TW-1:0] v8_itag, v8_otag;
  logic v16_iv, v16_ir, v16_ov, v16_or; logic [1:0] v16_op;
  logic [15:0] v16_a, v16_b, v16_res;  logic [31:0]  v16_prod; logic [TW-1:0] v16_itag, v16_otag;
  logic v64_iv, v64_ir, v64_ov, v64_or; logic [1:0] v64_op;
  logic [63:0] v64_a, v64_b, v64_res;  logic [127:0] v64_prod; logic [TW-1:0] v64_itag, v64_otag;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  typedef struct packed {
    logic [127:0] prod;
    logic [63:0]  res;
    logic [7:0]   tag;
  } exp_t;

  vedic_mul_pipelined #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_product(out_product), .out_tag(out_tag)
  );
  vedic_mul_pipelined #(.WIDTH(8), .TAG_W(TW)) u8 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(v8_iv), .in_ready(v8_ir),
    .in_op(v8_op), .in_a(v8_a), .in_b(v8_b), .in_tag(v8_itag), .out_valid(v8_ov),
    .out_ready(v8_or), .out_result(v8_res), .out_product(v8_prod), .out_tag(v8_otag)
  );
  vedic_mul_pipelined #(.WIDTH(16), .TAG_W(TW)) u16 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(v16_iv), .in_ready(v16_ir),
    .in_op(v16_op), .in_a(v16_a), .in_b(v16_b), .in_tag(v16_itag), .out_valid(v16_ov),
    .out_ready(v16_or), .out_result(v16_res), .out_product(v16_prod), .out_tag(v16_otag)
  );
  vedic_mul_pipelined #(.WIDTH(64), .TAG_W(TW)) u64 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(v64_iv), .in_ready(v64_ir),
    .in_op(v64_op), .in_a(v64_a), .in_b(v64_b), .in_tag(v64_itag), .out_valid(v64_ov),
    .out_ready(v64_or), .out_result(v64_res), .out_product(v64_prod), .out_tag(v64_otag)
  );

  // Reference: exact signed/unsigned product in wide integer arithmetic, reduced mod 2^(2w).
  function automatic logic [127:0] ref_prod(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int unsigned w);
    logic signed [129:0] sa, sb, p;
    logic [127:0] r;
    sa = $signed({66'd0, a});
    sb = $signed({66'd0, b});
    if (op != 2'b11 && a[6'(w - 1)]) sa = sa - (130'sd1 <<< w);
    if (op[1] == 1'b0 && b[6'(w - 1)]) sb = sb - (130'sd1 <<< w);
    p = sa * sb;
    r = p[127:0];
    if (w < 64) r = r & ((128'd1 << (2 * w)) - 128'd1);
    return r;
  endfunction

  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [127:0] p,
                                          input int unsigned w);
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (op == 2'b00) return p[63:0] & m;
    return 64'(p >> w) & m;
  endfunction

  function automatic logic [63:0] rand_opnd(input int unsigned w);
    logic [63:0] v, m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'd1 << (w - 1);
      3:       v = (64'd1 << (w - 1)) - 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & m;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_product !== '0) begin n_fail++; $display("FAIL reset_product got %h want 0", out_product); end
    n_cmp++; if (out_result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", out_result); end
    n_cmp++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_tag got %h want 0", out_tag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [9] = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
    logic [31:0] as  [9] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD,
                             32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [9] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000007,
                             32'h12345678, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    logic [63:0] ps  [9] = '{64'hFFFFFFFE00000001, 64'h4000000000000000, 64'hFFFFFFFF80000000,
                             64'hFFFFFFFF00000001, 64'hFFFFFFFFFFFFFFEB, 64'h0, 64'h1,
                             64'h0000000100000000, 64'h8000000080000000};
    logic [31:0] rs  [9] = '{32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEB,
                             32'h0, 32'h0, 32'h00000001, 32'h80000000};
    int unsigned lat;
    for (int unsigned i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = ops[i]; in_a = as[i]; in_b = bs[i]; in_tag = TW'(i); out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin @(negedge clk); lat++; end
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL dir%0d_latency got %0d want 3", i, lat); end
      n_cmp++; if (out_product !== ps[i]) begin n_fail++; $display("FAIL dir%0d_product got %h want %h", i, out_product, ps[i]); end
      n_cmp++; if (out_result !== rs[i]) begin n_fail++; $display("FAIL dir%0d_result got %h want %h", i, out_result, rs[i]); end
      n_cmp++; if (out_tag !== TW'(i)) begin n_fail++; $display("FAIL dir%0d_tag got %0d want %0d", i, out_tag, i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o [6];
    logic [31:0] a [6], b [6];
    exp_t        e [6];
    logic [63:0] snap_p; logic [31:0] snap_r; logic [TW-1:0] snap_t;
    int unsigned sent = 0, recv = 0, cyc = 0, stall_left = 0;
    bit seen_first = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      o[i] = 2'($urandom); a[i] = 32'(rand_opnd(W)); b[i] = 32'(rand_opnd(W));
      e[i].prod = ref_prod(o[i], 64'(a[i]), 64'(b[i]), W);
      e[i].res  = ref_res(o[i], e[i].prod, W);
      e[i].tag  = 8'(i);
    end
    @(negedge clk);
    while (recv < 6 && cyc < 60) begin
      @(negedge clk); cyc++;
      in_valid = (sent < 6);
      if (sent < 6) begin in_op = o[sent]; in_a = a[sent]; in_b = b[sent]; in_tag = TW'(sent); end
      if (!seen_first && out_valid) begin
        seen_first = 1; stall_left = 4;
        snap_p = out_product; snap_r = out_result; snap_t = out_tag;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %0b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_product !== snap_p || out_result !== snap_r || out_tag !== snap_t) begin
          n_fail++; $display("FAIL stall_hold got v=%0b p=%h r=%h t=%0d want v=1 p=%h r=%h t=%0d",
                             out_valid, out_product, out_result, out_tag, snap_p, snap_r, snap_t);
        end
        stall_left--;
      end else if (seen_first) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_gap got out_valid=%0b want 1 (result %0d)", out_valid, recv);
        end else begin
          if (out_product !== e[recv].prod[63:0] || out_result !== e[recv].res[31:0] || out_tag !== TW'(recv)) begin
            n_fail++; $display("FAIL b2b_result%0d got p=%h r=%h t=%0d want p=%h r=%h t=%0d", recv,
                               out_product, out_result, out_tag, e[recv].prod[63:0], e[recv].res[31:0], recv);
          end
          recv++;
        end
      end
      if (in_valid && in_ready) sent++;
    end
    n_cmp++; if (recv !== 6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", recv); end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_flush();
    int unsigned lat;
    logic [127:0] p;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'($urandom); in_a = $urandom; in_b = $urandom; in_tag = TW'(i); out_ready = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_tag = 5'd9;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_quiet%0d got out_valid=%0b want 0", i, out_valid); end
    end
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'(rand_opnd(W)); in_b = 32'(rand_opnd(W)); in_tag = 5'd21;
    p = ref_prod(2'b01, 64'(in_a), 64'(in_b), W);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL post_flush_latency got %0d want 3", lat); end
    n_cmp++; if (out_product !== p[63:0] || out_result !== p[63:32] || out_tag !== 5'd21) begin
      n_fail++; $display("FAIL post_flush_result got p=%h t=%0d want p=%h t=21", out_product, out_tag, p[63:0]);
    end
  endtask

  task automatic test_async_reset();
    int unsigned cyc = 0;
    out_ready = 1'b1;
    do begin
      @(negedge clk); cyc++;
      in_valid = 1'b1; in_op = 2'($urandom); in_a = $urandom | 32'h1; in_b = $urandom | 32'h1; in_tag = 5'h1F;
    end while (!out_valid && cyc < 10);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_fill got out_valid=%0b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_product !== '0 || out_result !== '0 || out_tag !== '0) begin
      n_fail++; $display("FAIL arst_clear got v=%0b p=%h r=%h t=%0d want all 0", out_valid, out_product, out_result, out_tag);
    end
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_discard%0d got out_valid=%0b want 0", i, out_valid); end
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    for (int unsigned c = 0; c < 320; c++) begin
      @(negedge clk);
      if (c < 300) begin
        in_valid = ($urandom_range(0, 3) != 0); in_op = 2'($urandom);
        in_a = 32'(rand_opnd(W)); in_b = 32'(rand_opnd(W)); in_tag = TW'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd32_spurious got tag %0d want no result", out_tag);
        end else begin
          e = q.pop_front();
          if (out_product !== e.prod[63:0] || out_result !== e.res[31:0] || out_tag !== e.tag[TW-1:0]) begin
            n_fail++; $display("FAIL rnd32_result got p=%h r=%h t=%0d want p=%h r=%h t=%0d",
                               out_product, out_result, out_tag, e.prod[63:0], e.res[31:0], e.tag[TW-1:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.prod = ref_prod(in_op, 64'(in_a), 64'(in_b), W);
        e.res  = ref_res(in_op, e.prod, W);
        e.tag  = 8'(in_tag);
        q.push_back(e);
      end
    end
    n_cmp++; if (q.size() !== 0) begin n_fail++; $display("FAIL rnd32_drain got %0d pending want 0", q.size()); end
  endtask

  task automatic test_random_widths();
    exp_t q8[$], q16[$], q64[$];
    exp_t e;
    for (int unsigned c = 0; c < 320; c++) begin
      @(negedge clk);
      if (c < 300) begin
        v8_iv  = ($urandom_range(0, 2) != 0); v8_op  = 2'($urandom); v8_itag  = TW'($urandom);
        v8_a   = 8'(rand_opnd(8));   v8_b   = 8'(rand_opnd(8));   v8_or  = ($urandom_range(0, 3) != 0);
        v16_iv = ($urandom_range(0, 2) != 0); v16_op = 2'($urandom); v16_itag = TW'($urandom);
        v16_a  = 16'(rand_opnd(16)); v16_b  = 16'(rand_opnd(16)); v16_or = ($urandom_range(0, 3) != 0);
        v64_iv = ($urandom_range(0, 2) != 0); v64_op = 2'($urandom); v64_itag = TW'($urandom);
        v64_a  = rand_opnd(64);      v64_b  = rand_opnd(64);      v64_or = ($urandom_range(0, 3) != 0);
      end else begin
        v8_iv = 1'b0; v16_iv = 1'b0; v64_iv = 1'b0;
        v8_or = 1'b1; v16_or = 1'b1; v64_or = 1'b1;
      end
      #1;
      if (v8_ov && v8_or) begin
        n_cmp++;
        if (q8.size() == 0) begin n_fail++; $display("FAIL rnd8_spurious got tag %0d want no result", v8_otag); end
        else begin
          e = q8.pop_front();
          if (v8_prod !== e.prod[15:0] || v8_res !== e.res[7:0] || v8_otag !== e.tag[TW-1:0]) begin
            n_fail++; $display("FAIL rnd8_result got p=%h r=%h t=%0d want p=%h r=%h t=%0d",
                               v8_prod, v8_res, v8_otag, e.prod[15:0], e.res[7:0], e.tag[TW-1:0]);
          end
        end
      end
      if (v16_ov && v16_or) begin
        n_cmp++;
        if (q16.size() == 0) begin n_fail++; $display("FAIL rnd16_spurious got tag %0d want no result", v16_otag); end
        else begin
          e = q16.pop_front();
          if (v16_prod !== e.prod[31:0] || v16_res !== e.res[15:0] || v16_otag !== e.tag[TW-1:0]) begin
            n_fail++; $display("FAIL rnd16_result got p=%h r=%h t=%0d want p=%h r=%h t=%0d",
                               v16_prod, v16_res, v16_otag, e.prod[31:0], e.res[15:0], e.tag[TW-1:0]);
          end
        end
      end
      if (v64_ov && v64_or) begin
        n_cmp++;
        if (q64.size() == 0) begin n_fail++; $display("FAIL rnd64_spurious got tag %0d want no result", v64_otag); end
        else begin
          e = q64.pop_front();
          if (v64_prod !== e.prod || v64_res !== e.res || v64_otag !== e.tag[TW-1:0]) begin
            n_fail++; $display("FAIL rnd64_result got p=%h r=%h t=%0d want p=%h r=%h t=%0d",
                               v64_prod, v64_res, v64_otag, e.prod, e.res, e.tag[TW-1:0]);
          end
        end
      end
      if (v8_iv && v8_ir) begin
        e.prod = ref_prod(v8_op, 64'(v8_a), 64'(v8_b), 8); e.res = ref_res(v8_op, e.prod, 8);
        e.tag = 8'(v8_itag); q8.push_back(e);
      end
      if (v16_iv && v16_ir) begin
        e.prod = ref_prod(v16_op, 64'(v16_a), 64'(v16_b), 16); e.res = ref_res(v16_op, e.prod, 16);
        e.tag = 8'(v16_itag); q16.push_back(e);
      end
      if (v64_iv && v64_ir) begin
        e.prod = ref_prod(v64_op, v64_a, v64_b, 64); e.res = ref_res(v64_op, e.prod, 64);
        e.tag = 8'(v64_itag); q64.push_back(e);
      end
    end
    n_cmp++; if (q8.size() !== 0)  begin n_fail++; $display("FAIL rnd8_drain got %0d pending want 0", q8.size()); end
    n_cmp++; if (q16.size() !== 0) begin n_fail++; $display("FAIL rnd16_drain got %0d pending want 0", q16.size()); end
    n_cmp++; if (q64.size() !== 0) begin n_fail++; $display("FAIL rnd64_drain got %0d pending want 0", q64.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    v8_iv = 1'b0;  v8_or = 1'b1;  v8_op = '0;  v8_a = '0;  v8_b = '0;  v8_itag = '0;
    v16_iv = 1'b0; v16_or = 1'b1; v16_op = '0; v16_a = '0; v16_b = '0; v16_itag = '0;
    v64_iv = 1'b0; v64_or = 1'b1; v64_op = '0; v64_a = '0; v64_b = '0; v64_itag = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    test_random_widths();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vedic_mul_pipelined.md
Name: vedic_mul_pipelined

Overview:
- Parametrised, pipelined successor to the combinational vedic multipliers.
- Splits each operand into halves, forms four half-width vedic partial products, then combines them through registered adder stages.
- Adds signed/unsigned operand modes (RISC-V MUL/MULH/MULHSU/MULHU), valid/ready handshake with backpressure, tag passthrough and flush.
- Sits in the vector/integer execute lane as the multiply functional unit.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- TAG_W, 5, width of sideband tag carried with each operation (e.g. destination register).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; kills all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit accepts input this cycle.
- in_op  in  2  00 MUL, 01 MULH (s×s), 10 MULHSU (s×u), 11 MULHU (u×u).
- in_a  in  WIDTH  operand A (rs1).
- in_b  in  WIDTH  operand B (rs2).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  low half for MUL, high half otherwise.
- out_product  out  2*WIDTH  full two's-complement product.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: all stage valid bits = 0; out_valid = 0; out_result, out_product, out_tag = 0. Async assert, sync deassert expected from the reset tree.
- Global advance: en = !out_valid | out_ready. in_ready = en & !flush.
- Accept occurs when in_valid & in_ready. All stages shift together when en = 1 and hold when en = 0. Bubbles propagate as valid = 0.
- S1, operand conditioning (registered):
  - sign_a = in_a[W-1] for MUL/MULH/MULHSU, else 0.
  - sign_b = in_b[W-1] for MUL/MULH only.
  - mag = sign ? -x : x, taken as an unsigned W-bit value; -2^(W-1) maps to 2^(W-1).
  - neg = sign_a ^ sign_b.
  - op, tag and neg are carried forward.
- S2, partial products (registered): four unsigned (W/2)×(W/2) vedic products: ll, lh, hl, hh.
- S3, combine (output register):
  - P = ll + ((lh + hl) << W/2) + (hh << W).
  - The mid sum is W+1 bits; its carry lands at bit 3W/2.
  - out_product = neg ? -P : P, modulo 2^(2W).
  - out_result = MUL ? out_product[W-1:0] : out_product[2W-1:W].
- Latency: exactly 3 cycles from accept to out_valid with out_ready held high. Throughput is 1 op/cycle.
- Results leave in strict acceptance order. Tag stays aligned with its data.
- Backpressure: when out_valid & !out_ready:
  - All stages hold.
  - out_* remain stable.
  - in_ready = 0.
  - No operation is lost or duplicated.
- flush (synchronous, has priority over accept and advance):
  - Next cycle, all stage valid bits and out_valid = 0.
  - The input presented during flush is not accepted.
  - Data registers may keep stale values.
- Simultaneous out_valid & out_ready & in_valid: the result is consumed and the new op is accepted in the same cycle.
- Reset mid-operation: all in-flight ops are discarded immediately; outputs return to their reset values.
- Zero operands, and -1 in signed modes, follow the same path; no special-casing.

Test Plan:
- W=32: MULHU 0xFFFFFFFF×0xFFFFFFFF, out_ready=1 -> out_valid exactly 3 cycles after accept; out_product=0xFFFFFFFE00000001; out_result=0xFFFFFFFE.
- MULH 0x80000000×0x80000000 -> out_product=0x4000000000000000, out_result=0x40000000. MULH 0x80000000×0x00000001 -> out_result=0xFFFFFFFF.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF -> out_product=0xFFFFFFFF00000001, out_result=0xFFFFFFFF. MUL 0xFFFFFFFD×0x00000007 -> out_result=0xFFFFFFEB.
- Stream 6 ops, tags 0..5, back-to-back, with out_ready=0 for 4 cycles after the first result:
  - in_ready drops on the first stall cycle.
  - out_* hold stable throughout the stall.
  - All 6 results arrive in tag order with no gaps once out_ready=1.
- Fill the pipe with 3 ops, then pulse flush with in_valid=1:
  - in_ready=0 during flush.
  - No out_valid in the following 4 cycles.
  - The next op accepted after flush returns its correct result with latency 3.
- Assert rst asynchronously mid-stream -> outputs zero and out_valid=0 without waiting for a clock edge. After release, random signed/unsigned ops match the reference model for WIDTH=8, 16 and 64 builds.
